// File: rtl/dir_pkg.sv
// Shared directory message definitions: opcodes, unit ids and message payload layout.
package dir_pkg;

  localparam int unsigned DIR_OP_W    = 3;
  localparam int unsigned DIR_UNIT_W  = 2;
  localparam int unsigned DIR_ADDR_W  = 32;
  localparam int unsigned DIR_CL_SIZE = 128;

  localparam logic [DIR_OP_W-1:0] DIR_NOOP  = 3'd0;
  localparam logic [DIR_OP_W-1:0] DIR_REPLY = 3'd2;
  localparam logic [DIR_OP_W-1:0] DIR_RD    = 3'd3;
  localparam logic [DIR_OP_W-1:0] DIR_WR    = 3'd4;
  localparam logic [DIR_OP_W-1:0] DIR_INV   = 3'd5;
  localparam logic [DIR_OP_W-1:0] DIR_UPD   = 3'd6;
  localparam logic [DIR_OP_W-1:0] DIR_RWITM = 3'd7;

  localparam logic [DIR_UNIT_W-1:0] UNIT_IC  = 2'd1;
  localparam logic [DIR_UNIT_W-1:0] UNIT_DC  = 2'd2;
  localparam logic [DIR_UNIT_W-1:0] UNIT_MEM = 2'd3;

  // Sideband without the line data; the data width is a per-channel parameter.
  typedef struct packed {
    logic [DIR_OP_W-1:0]   op;
    logic [DIR_UNIT_W-1:0] src;
    logic [DIR_UNIT_W-1:0] dest;
    logic [DIR_ADDR_W-1:0] addr;
  } dir_hdr_t;

  typedef struct packed {
    logic [DIR_OP_W-1:0]    op;
    logic [DIR_UNIT_W-1:0]  src;
    logic [DIR_UNIT_W-1:0]  dest;
    logic [DIR_ADDR_W-1:0]  addr;
    logic [DIR_CL_SIZE-1:0] data;
  } dir_msg_t;

  // Opcodes 0 (NOOP) and 1 (unassigned) carry no message.
  function automatic logic dir_op_valid(input logic [DIR_OP_W-1:0] op);
    return op >= DIR_REPLY;
  endfunction

endpackage

// File: rtl/dir_msg_ram.sv
// DEPTH x W message storage: one synchronous write port, one asynchronous read port.
module dir_msg_ram #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 8
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dir_msg_queue.sv
// Receive-side queue for one directory output channel; FWFT dequeue with registered head.
module dir_msg_queue
  import dir_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CL_SIZE   = 128,
  parameter int unsigned HAS_DATA  = 1,
  parameter int unsigned AF_MARGIN = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        alloc,
  input  logic [DIR_OP_W-1:0]         operation,
  input  logic [DIR_UNIT_W-1:0]       src_in,
  input  logic [DIR_UNIT_W-1:0]       dest_in,
  input  logic [DIR_ADDR_W-1:0]       addr_in,
  input  logic [CL_SIZE-1:0]          data_in,
  output logic                        deq_valid,
  input  logic                        deq_ready,
  output logic [DIR_OP_W-1:0]         deq_operation,
  output logic [DIR_UNIT_W-1:0]       deq_src,
  output logic [DIR_UNIT_W-1:0]       deq_dest,
  output logic [DIR_ADDR_W-1:0]       deq_addr,
  output logic [CL_SIZE-1:0]          deq_data,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        almost_full,
  output logic                        overflow,
  output logic                        bad_op
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned DW = (HAS_DATA != 0) ? CL_SIZE : 1;
  localparam int unsigned HW = $bits(dir_hdr_t);
  localparam int unsigned EW = HW + DW;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  dir_hdr_t      hdr_q, hdr_d;
  logic [DW-1:0] data_q, data_d;
  logic          af_q, af_d;
  logic          ovf_q, ovf_d;
  logic          bad_q, bad_d;

  logic          push_req, push_ok, pop, full, bypass;
  dir_hdr_t      wr_hdr;
  logic [DW-1:0] wr_data;
  logic [EW-1:0] wr_entry, rd_entry;

  assign push_req = alloc && dir_op_valid(operation);
  assign full     = (count_q == CW'(DEPTH));
  assign pop      = valid_q && deq_ready;
  assign push_ok  = push_req && (!full || pop);

  assign wr_hdr   = '{op: operation, src: src_in, dest: dest_in, addr: addr_in};
  assign wr_data  = (HAS_DATA != 0) ? DW'(data_in) : '0;
  assign wr_entry = {wr_hdr, wr_data};

  dir_msg_ram #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_ram (
    .clk     (clk),
    .we_i    (push_ok),
    .waddr_i (wptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rptr_d),
    .rdata_o (rd_entry)
  );

  // Next head comes from the incoming push when nothing older survives this edge.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    valid_d = valid_q;
    hdr_d   = hdr_q;
    data_d  = data_q;
    af_d    = af_q;
    ovf_d   = ovf_q;
    bad_d   = bad_q;
    bypass  = 1'b0;

    if (push_ok) wptr_d = wptr_q + PW'(1);
    if (pop)     rptr_d = rptr_q + PW'(1);
    count_d = count_q + CW'(push_ok) - CW'(pop);
    valid_d = (count_d != '0);
    bypass  = push_ok && ((count_q - CW'(pop)) == '0);

    if (!valid_d) begin
      hdr_d  = '0;
      data_d = '0;
    end else if (bypass) begin
      {hdr_d, data_d} = wr_entry;
    end else begin
      {hdr_d, data_d} = rd_entry;
    end

    af_d  = (CW'(DEPTH) - count_d) <= CW'(AF_MARGIN);
    ovf_d = ovf_q | (push_req && full && !pop);
    bad_d = bad_q | (alloc && !dir_op_valid(operation));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      hdr_q   <= '0;
      data_q  <= '0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      valid_q <= valid_d;
      hdr_q   <= hdr_d;
      data_q  <= data_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
      bad_q   <= bad_d;
    end
  end

  assign deq_valid     = valid_q;
  assign deq_operation = hdr_q.op;
  assign deq_src       = hdr_q.src;
  assign deq_dest      = hdr_q.dest;
  assign deq_addr      = hdr_q.addr;
  assign deq_data      = (HAS_DATA != 0) ? CL_SIZE'(data_q) : '0;
  assign count         = count_q;
  assign almost_full   = af_q;
  assign overflow      = ovf_q;
  assign bad_op        = bad_q;

endmodule
